// File: rtl/hdmi_clk_pkg.sv
// hdmi_clk_pkg: sequencer state type, default dwell times and counter sizing helpers
package hdmi_clk_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        DIV_RST,
        SETTLE,
        PIX_REL,
        RUN
    } seq_state_t;

    localparam int DEF_PLL_RST_CYC      = 16;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYC = 65536;
    localparam int DEF_DIV_RST_CYC      = 8;
    localparam int DEF_SETTLE_CYC       = 32;
    localparam int DEF_PIX_REL_CYC      = 16;
    localparam int DEF_CALIB_GAP        = 8;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit, cleared by reset
module sync_2ff (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!resetn) {q, meta} <= 2'b00;
        else         {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/hdmi_clk_seq.sv
// hdmi_clk_seq: ordered reset release for the HDMI TX clocking chain with lock-loss recovery and paced divider calibration
module hdmi_clk_seq
    import hdmi_clk_pkg::*;
#(
    parameter int PLL_RST_CYC      = DEF_PLL_RST_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int DIV_RST_CYC      = DEF_DIV_RST_CYC,
    parameter int SETTLE_CYC       = DEF_SETTLE_CYC,
    parameter int PIX_REL_CYC      = DEF_PIX_REL_CYC,
    parameter int CALIB_GAP        = DEF_CALIB_GAP
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    input  logic       calib_req,
    output logic       pll_rst,
    output logic       clkdiv_resetn,
    output logic       oser_rst,
    output logic       pix_resetn,
    output logic       calib,
    output logic       ready,
    output logic [7:0] retry_cnt
);

    localparam int CW = cnt_w(max2(max2(PLL_RST_CYC, LOCK_TIMEOUT_CYC),
                                   max2(DIV_RST_CYC, max2(SETTLE_CYC, PIX_REL_CYC))));
    localparam int SW = cnt_w(LOCK_STABLE_CYC);
    localparam int GW = cnt_w(CALIB_GAP);

    seq_state_t    state, st_nxt;
    logic [CW-1:0] cnt, cnt_ld;
    logic [SW-1:0] stab;
    logic [GW-1:0] gap;
    logic          lock_s, pend, done, stable, lost, in_run, fire;

    sync_2ff u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pll_lock),
        .q      (lock_s)
    );

    // the shared dwell counter doubles as the lock timeout while in WAIT_LOCK
    assign done   = cnt == '0;
    assign stable = lock_s && stab == SW'(LOCK_STABLE_CYC - 1);
    assign lost   = !lock_s && state inside {DIV_RST, SETTLE, PIX_REL, RUN};

    always_comb begin
        st_nxt = state;
        case (state)
            PLL_RST:   st_nxt = done ? WAIT_LOCK : PLL_RST;
            WAIT_LOCK: st_nxt = stable ? DIV_RST : done ? PLL_RST : WAIT_LOCK;
            DIV_RST:   st_nxt = done ? SETTLE : DIV_RST;
            SETTLE:    st_nxt = done ? PIX_REL : SETTLE;
            PIX_REL:   st_nxt = done ? RUN : PIX_REL;
            default:   st_nxt = RUN;
        endcase
        if (lost) st_nxt = PLL_RST;
    end

    assign cnt_ld = st_nxt == PLL_RST   ? CW'(PLL_RST_CYC - 1)      :
                    st_nxt == WAIT_LOCK ? CW'(LOCK_TIMEOUT_CYC - 1) :
                    st_nxt == DIV_RST   ? CW'(DIV_RST_CYC - 1)      :
                    st_nxt == SETTLE    ? CW'(SETTLE_CYC - 1)       :
                    st_nxt == PIX_REL   ? CW'(PIX_REL_CYC - 1)      : '0;

    // calibration only runs while staying in RUN; a same-cycle request fires immediately
    assign in_run = state == RUN && st_nxt == RUN;
    assign fire   = in_run && (pend || calib_req) && gap == '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= PLL_RST;
            cnt           <= CW'(PLL_RST_CYC - 1);
            stab          <= '0;
            gap           <= '0;
            pend          <= 1'b0;
            pll_rst       <= 1'b1;
            clkdiv_resetn <= 1'b0;
            oser_rst      <= 1'b1;
            pix_resetn    <= 1'b0;
            calib         <= 1'b0;
            ready         <= 1'b0;
            retry_cnt     <= '0;
        end else begin
            state         <= st_nxt;
            cnt           <= st_nxt != state ? cnt_ld : cnt - CW'(!done);
            stab          <= state == WAIT_LOCK && lock_s && !stable ? stab + SW'(1) : '0;
            if (state == WAIT_LOCK && done && !stable && retry_cnt != 8'hFF)
                retry_cnt <= retry_cnt + 8'd1;
            pll_rst       <= st_nxt == PLL_RST;
            clkdiv_resetn <= st_nxt inside {SETTLE, PIX_REL, RUN};
            oser_rst      <= !(st_nxt inside {PIX_REL, RUN});
            pix_resetn    <= st_nxt == RUN;
            ready         <= st_nxt == RUN;
            calib         <= fire;
            pend          <= in_run && !fire && (pend || calib_req);
            gap           <= !in_run ? '0 : fire ? GW'(CALIB_GAP) : gap - GW'(gap != '0);
        end
    end

endmodule
